// File: rtl/u_bi_to_bin_pkg.sv
// Shared stochastic-computing definitions: default word width and the
// converter FSM state encoding.
package u_bi_to_bin_pkg;

  localparam int unsigned SC_DATAWD = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } bi_state_e;

endpackage

// File: rtl/u_bi_to_bin_win_counter.sv
// Ones/window counter pair for one conversion window of 2^DATAWD enabled samples.
module u_win_counter
  import u_bi_to_bin_pkg::*;
#(
  parameter int unsigned DATAWD = SC_DATAWD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic              bit_in,
  output logic [DATAWD:0]   ones,
  output logic              last
);

  logic [DATAWD:0]   ones_d, ones_q;
  logic [DATAWD-1:0] win_d,  win_q;

  always_comb begin
    ones_d = ones_q;
    win_d  = win_q;
    if (clr) begin
      ones_d = '0;
      win_d  = '0;
    end else if (en) begin
      ones_d = ones_q + (DATAWD+1)'(bit_in);
      win_d  = win_q + DATAWD'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_q <= '0;
      win_q  <= '0;
    end else begin
      ones_q <= ones_d;
      win_q  <= win_d;
    end
  end

  assign ones = ones_q;
  // The window counter wraps to 0 on the last sample, so no extra clear is needed.
  assign last = en && (win_q == '1);

endmodule

// File: rtl/u_bi_to_bin.sv
// Bipolar stochastic bitstream to offset-binary converter: counts ones over a
// window of 2^DATAWD enabled samples and presents the saturated count.
module u_bi_to_bin
  import u_bi_to_bin_pkg::*;
#(
  parameter int unsigned DATAWD = SC_DATAWD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              iEn,
  input  logic              iBit,
  input  logic              iReady,
  output logic [DATAWD-1:0] oVal,
  output logic              oValid,
  output logic              oBusy
);

  bi_state_e         state_d, state_q;
  logic [DATAWD-1:0] oval_d, oval_q;
  logic [DATAWD:0]   ones, ones_final;
  logic              cnt_en, cnt_clr, cnt_last;

  u_win_counter #(.DATAWD(DATAWD)) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (cnt_en),
    .clr    (cnt_clr),
    .bit_in (iBit),
    .ones   (ones),
    .last   (cnt_last)
  );

  // Result includes the last sample, which is captured on the same edge.
  assign ones_final = ones + (DATAWD+1)'(iBit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      oval_q  <= '0;
    end else begin
      state_q <= state_d;
      oval_q  <= oval_d;
    end
  end

  always_comb begin
    state_d = state_q;
    oval_d  = oval_q;
    cnt_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          cnt_clr = 1'b1;
        end
      end
      ST_RUN: begin
        if (cnt_last) begin
          state_d = ST_DONE;
          oval_d  = ones_final[DATAWD] ? '1 : ones_final[DATAWD-1:0];
        end
      end
      ST_DONE: begin
        if (iReady) begin
          if (start) begin
            state_d = ST_RUN;
            cnt_clr = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_en = (state_q == ST_RUN) && iEn;
    oBusy  = (state_q == ST_RUN);
    oValid = (state_q == ST_DONE);
    oVal   = oval_q;
  end

endmodule

// File: doc/u_bi_to_bin.md
U_BI_TO_BIN -- requirements
Module: u_bi_to_bin

Interface
REQ-001 Parameter DATAWD, default 8, SHALL set the output word width; the observation window SHALL be 2^DATAWD enabled cycles.
REQ-002 clk  input  1  clock; all state SHALL change on the rising edge.
REQ-003 rst_n  input  1  asynchronous reset, active-low.
REQ-004 start  input  1  request to begin a new conversion window.
REQ-005 iEn  input  1  sample qualifier; cycles with iEn=0 SHALL neither sample nor advance the window.
REQ-006 iBit  input  1  bipolar stochastic bitstream, e.g. the oC output of the bipolar multiplier.
REQ-007 iReady  input  1  downstream accepts the result.
REQ-008 oVal  output  DATAWD  offset-binary result, where code 2^(DATAWD-1) represents 0.0; matches the multiplier iB encoding.
REQ-009 oValid  output  1  oVal holds a completed result.
REQ-010 oBusy  output  1  high while a window is in progress.

Function
REQ-011 The FSM SHALL have three states: IDLE, RUN and DONE; the reset state SHALL be IDLE.
REQ-012 IDLE with start=1 SHALL enter RUN on the next edge and clear the ones counter and the window counter to 0.
REQ-013 In RUN, each cycle with iEn=1 SHALL add iBit to the ones counter (DATAWD+1 bits) and increment the window counter (DATAWD bits).
REQ-014 In RUN, the cycle with iEn=1 and window counter = 2^DATAWD-1 SHALL be the last sample; the next edge SHALL enter DONE and register oVal.
REQ-015 oVal SHALL equal min(ones_final, 2^DATAWD-1), where ones_final includes the last sample; all-ones (count 2^DATAWD) SHALL saturate to 2^DATAWD-1.
REQ-016 Latency from the edge that captures the last sample to oValid=1 SHALL be 0 cycles: oValid SHALL rise on that same edge.
REQ-017 oValid SHALL be 1 exactly in DONE; oVal SHALL stay stable while oValid=1.
REQ-018 In DONE with iReady=1, the FSM SHALL leave DONE on the next edge: to RUN (counters cleared) if start=1, otherwise to IDLE.
REQ-019 In DONE with iReady=0, the FSM SHALL hold DONE regardless of start.
REQ-020 In RUN, start SHALL be ignored; there is no restart mid-window.
REQ-021 oBusy SHALL be 1 exactly in RUN.
REQ-022 oVal SHALL retain its last value in IDLE and RUN, and SHALL be 0 after reset.
REQ-023 Window completion and iEn=0 gaps SHALL not interact: a window SHALL always contain exactly 2^DATAWD enabled samples.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE, ones counter=0, window counter=0, oVal=0, oValid=0, oBusy=0.
REQ-025 Reset asserted mid-window SHALL discard the partial count; no oValid SHALL follow the release of reset.

Structure
REQ-026 The FSM state enum and DATAWD default SHALL live in the shared stochastic-computing package used by the multiplier blocks.
REQ-027 The ones/window counter pair SHALL be a single sub-module, u_win_counter (enable, clear, bit in, count out, last flag).
REQ-028 There SHALL be no combinational path from iBit to oVal or oValid.

Verification (DATAWD=4, window=16)
REQ-029 start pulse, iEn=1, iBit=1 for 12 of 16 cycles -> oValid rises 16 cycles after RUN entry with oVal=12 (bipolar +0.5).
REQ-030 iBit all 1 for 16 samples -> oVal=15 (saturated); iBit all 0 -> oVal=0.
REQ-031 iEn toggling 1,0 with iBit=1 on enabled cycles only, 8 ones -> oValid after 32 cycles, oVal=8 (bipolar 0.0).
REQ-032 iReady=0 held 5 cycles in DONE, with start pulsed -> oValid and oVal held; then iReady=1 with start=1 -> next edge RUN, oBusy=1, oValid=0.
REQ-033 rst_n pulsed low at sample 7 of a window -> all outputs 0 immediately, IDLE, no oValid afterwards until a new start completes a window.
REQ-034 Multiplier chain: iA and iB streams at bipolar +0.5 and -0.5 fed through the multiplier into this block -> oVal within ±1 LSB of code 6 (-0.25).
